// File: rtl/axi_chan_buf_pkg.sv
// Shared widths, reset constants and packed channel word layouts for axi_chan_buf.
package axi_chan_buf_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEPTH_DEF = 4;
  typedef logic [cnt_w(DEPTH_DEF)-1:0] cnt_t;

  localparam logic RST_ALMOST_FULL  = 1'b0;
  localparam logic RST_OUT_DATA_BIT = 1'b0;

  // AW channel word: 41 payload bits, zero padded up to the default DATA_W.
  localparam int AW_DATA_W = 47;
  typedef struct packed {
    logic [AW_DATA_W-42:0] pad;
    logic [31:0]           addr;
    logic [3:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_word_t;

endpackage

// File: rtl/axi_chan_buf_ctrl.sv
// Pointer, occupancy and handshake flag logic for axi_chan_buf.
// AXI_CHAN_BUF_BYPASS_EN lets an empty buffer present in_valid as out_valid.
module axi_chan_buf_ctrl
  import axi_chan_buf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3,
  parameter int PTR_W    = ptr_w(DEPTH),
  parameter int CNT_W    = cnt_w(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_in_valid,
  input  logic             i_out_ready,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic             o_wr_en,
  output logic [PTR_W-1:0] o_wptr,
  output logic [PTR_W-1:0] o_rptr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_almost_full
);

  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_afull;
  logic [PTR_W-1:0] w_wptr_nxt, w_rptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});

  // in_ready looks only at registered occupancy, never at out_ready.
  assign o_in_ready = !i_reset && !w_full;
`ifdef AXI_CHAN_BUF_BYPASS_EN
  assign o_out_valid = !w_empty || i_in_valid;
`else
  assign o_out_valid = !w_empty;
`endif

  assign w_push = i_in_valid && o_in_ready;
  assign w_pop  = o_out_valid && i_out_ready;

  // Next pointer/occupancy; flush overrides any handshake in the same cycle.
  always_comb begin
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_wptr_nxt  = {PTR_W{1'b0}};
      w_rptr_nxt  = {PTR_W{1'b0}};
      w_count_nxt = {CNT_W{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          w_wptr_nxt  = r_wptr + PTR_W'(1);
          w_count_nxt = r_count + CNT_W'(1);
        end
        2'b01: begin
          w_rptr_nxt  = r_rptr + PTR_W'(1);
          w_count_nxt = r_count - CNT_W'(1);
        end
        2'b11: begin
          w_wptr_nxt = r_wptr + PTR_W'(1);
          w_rptr_nxt = r_rptr + PTR_W'(1);
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end
  end

  // State registers; reset wins over flush.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_afull <= RST_ALMOST_FULL;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_afull <= (w_count_nxt >= CNT_W'(AFULL_TH));
    end
  end

  assign o_wr_en       = w_push && !i_flush;
  assign o_wptr        = r_wptr;
  assign o_rptr        = r_rptr;
  assign o_count       = r_count;
  assign o_almost_full = r_afull;

endmodule

// File: rtl/axi_chan_buf.sv
// AXI channel buffer: valid/ready on both sides, FWFT register array, flush and occupancy.
// Define AXI_CHAN_BUF_BYPASS_EN to pass words straight through while empty.
module axi_chan_buf
  import axi_chan_buf_pkg::*;
#(
  parameter int DATA_W   = 47,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wptr, w_rptr;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;

  axi_chan_buf_ctrl #(
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH),
    .PTR_W    (PTR_W),
    .CNT_W    (CNT_W)
  ) u_ctrl (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_flush       (flush),
    .i_in_valid    (in_valid),
    .i_out_ready   (out_ready),
    .o_in_ready    (in_ready),
    .o_out_valid   (out_valid),
    .o_wr_en       (w_wr_en),
    .o_wptr        (w_wptr),
    .o_rptr        (w_rptr),
    .o_count       (w_count),
    .o_almost_full (almost_full)
  );

  // Storage is deliberately not reset; an empty buffer masks its output instead.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[w_wptr] <= in_data;
    end
  end

  assign w_empty = (w_count == {CNT_W{1'b0}});
  assign count   = w_count;

`ifdef AXI_CHAN_BUF_BYPASS_EN
  assign out_data = !w_empty ? r_mem[w_rptr] :
                    (in_valid ? in_data : {DATA_W{RST_OUT_DATA_BIT}});
`else
  assign out_data = !w_empty ? r_mem[w_rptr] : {DATA_W{RST_OUT_DATA_BIT}};
`endif

endmodule

// File: tb/tb_axi_chan_buf.sv
// Randomised and directed bench for axi_chan_buf against a queue-based reference model.
module tb_axi_chan_buf;
  import axi_chan_buf_pkg::*;

  localparam int DW  = 47;
  localparam int DEP = 4;
  localparam int AF  = 3;

  logic          clock = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid, almost_full;
  logic [DW-1:0] in_data, out_data;
  logic [2:0]    count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  logic [DW-1:0] q[$];

  always #5 clock = ~clock;

  axi_chan_buf #(.DATA_W(DW), .DEPTH(DEP), .AFULL_TH(AF)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // One clock: drive inputs, check outputs mid-cycle against the model, advance the model.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [DW-1:0] d, input logic ordy);
    logic          e_rdy, e_vld;
    logic [DW-1:0] e_data;
    bit            byp;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    e_rdy  = !rst && (q.size() != DEP);
    e_vld  = (q.size() != 0);
    e_data = (q.size() != 0) ? q[0] : '0;
    byp    = 1'b0;
`ifdef AXI_CHAN_BUF_BYPASS_EN
    if (q.size() == 0 && iv) begin
      e_vld = 1'b1; e_data = d; byp = 1'b1;
    end
`endif
    #4;
    if (chk_en) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, e_rdy});
      check("out_valid", {63'd0, out_valid}, {63'd0, e_vld});
      check("count", {61'd0, count}, 64'(q.size()));
      check("almost_full", {63'd0, almost_full}, {63'd0, q.size() >= AF});
      if (e_vld) check("out_data", {17'd0, out_data}, {17'd0, e_data});
    end
    @(posedge clock);
    if (rst || fl) begin
      q.delete();
    end else begin
      if (e_vld && ordy && !byp) void'(q.pop_front());
      if (iv && e_rdy && !(byp && ordy)) q.push_back(d);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    // Reset for three cycles, then idle.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("rst_out_data", {17'd0, out_data}, 64'd0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Fill to full, then offer a fifth word that must be held off.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 1'b0);
    step(1'b0, 1'b0, 1'b1, DW'(5), 1'b0);
    check("full_count", {61'd0, count}, 64'd4);

    // Drain with pointer wrap.
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, DW'(10), 1'b0);
    step(1'b0, 1'b0, 1'b1, DW'(11), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("drained", {61'd0, count}, 64'd0);

    // Simultaneous push/pop at occupancy two.
    step(1'b0, 1'b0, 1'b1, DW'(32), 1'b0);
    step(1'b0, 1'b0, 1'b1, DW'(33), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, DW'(34 + i), 1'b1);
    check("pp_count", {61'd0, count}, 64'd2);

    // Backpressure stability.
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, DW'(64'h2AA_AAAA), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("stable_data", {17'd0, out_data}, 64'h2AA_AAAA);

    // Flush at occupancy three with a concurrent push.
    step(1'b0, 1'b0, 1'b1, DW'(7'h41), 1'b0);
    step(1'b0, 1'b0, 1'b1, DW'(7'h42), 1'b0);
    step(1'b0, 1'b1, 1'b1, DW'(7'h43), 1'b0);
    check("flush_count", {61'd0, count}, 64'd0);

    // Push into an empty buffer with out_ready high (bypass or one-cycle latency).
    step(1'b0, 1'b0, 1'b1, DW'(7), 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Random traffic with occasional flush and mid-burst reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199) == 0), ($urandom_range(31) == 0),
           ($urandom_range(2) != 0), rnd_d(), ($urandom_range(2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_chan_buf.md
Name: axi_chan_buf

Overview:
- Parametrised single-clock AXI channel buffer with full valid/ready handshake on both sides.
- Replaces edge-toggle pushing with true handshakes; generalises data width, depth and almost-full threshold; adds flush and occupancy reporting.
- Inserted per AXI channel (AW/W/AR/R/B) between a master/slave and the bus.
- Carries a packed channel word opaquely; packing and unpacking are done by the instantiator.

Parameters:
- DATA_W, 47, width of the packed channel word.
- DEPTH, 4, number of entries; power of two, >= 2.
- AFULL_TH, 3, occupancy at or above which almost_full asserts; 1..DEPTH.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  buffer can accept.
- in_data  in  DATA_W  upstream word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head entry.
- count  out  $clog2(DEPTH)+1  current occupancy.
- almost_full  out  1  count >= AFULL_TH.

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset values: in_ready=0 during reset, 1 on the first cycle after; out_valid=0; count=0; almost_full=0; out_data=0. Storage array is not reset. Read pointer, write pointer and count are cleared.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !reset & (count != DEPTH). It is decoded from registered state only, with no combinational path from out_ready.
  - When full, pushing in the same cycle as a pop is NOT allowed; in_ready stays 0 that cycle.
- Storage: write on push at wptr. out_data = mem[rptr] (first-word fall-through from a register array).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided from count, not from pointer compare.
- count update: push only +1; pop only -1; push and pop together leaves count unchanged with both pointers advanced; neither leaves it unchanged.
- Latency: a word pushed in cycle N is visible (out_valid=1) in cycle N+1 with bypass off.
- out_valid = (count != 0). Once asserted, out_valid and out_data stay stable until pop, flush or reset. This is the AXI stability rule.
- in_data is sampled only on push. in_data is don't-care when in_valid=0.
- flush: next cycle count=0, pointers=0, out_valid=0. A push or pop in the flush cycle is ignored. in_ready stays 1 during flush unless the buffer is full.
- Priority: reset > flush > push/pop.
- Reset asserted mid-burst: all entries are discarded; no partial word appears after reset.
- Boundaries:
  - Empty with pop attempted: no effect, since out_valid=0.
  - Full with push attempted: word is held upstream, since in_ready=0.
  - count is never outside 0..DEPTH.

Optional Feature:
- Macro: AXI_CHAN_BUF_BYPASS_EN.
- Defined: when count==0, in_valid=1 and out_ready=1, the word passes combinationally to out_data with out_valid=1 in the same cycle. It is not stored and count stays 0.
  - out_valid = (count!=0) | in_valid; out_data muxes in_data when count==0.
  - in_ready is unchanged.
  - The stability rule still holds, because a bypassed word is consumed in the cycle it is presented.
- Not defined: 1-cycle minimum latency as specified above, with no combinational in->out path.

Decomposition:
- Package axi_chan_buf_pkg holds:
  - localparam functions for pointer width ($clog2(DEPTH)) and count width;
  - typedef cnt_t;
  - constants for the reset values;
  - typedefs for packed channel words (aw_word_t: ADDR 32, LEN 4, SIZE 3, BURST 2, padded to DATA_W) so instantiators pack consistently.
- One sub-module, axi_chan_buf_ctrl, contains the pointer/count/flag logic. The top holds the storage array and the bypass mux.

Test Plan:
- Reset then idle, DEPTH=4: hold reset 3 cycles -> out_valid=0, count=0, almost_full=0, in_ready=0 during reset and 1 on the first cycle after.
- Fill: push 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=0 -> count 1..4; almost_full rises when count=3; in_ready=0 at count=4; a 5th word 0x5 is held upstream.
- Drain with wrap: from full, pop 2, push 0xA,0xB, pop all -> output order 0x1,0x2,0x3,0x4,0xA,0xB and count returns to 0.
- Simultaneous push/pop at count=2 for 10 cycles -> count stays 2 and data order is preserved.
- Backpressure stability: out_ready=0 for 5 cycles with out_valid=1 -> out_data unchanged (0x2AA_AAAA) throughout.
- Flush and bypass:
  - Flush at count=3 with a concurrent push -> count=0 next cycle and the pushed word is dropped.
  - With AXI_CHAN_BUF_BYPASS_EN, push 0x7 into an empty buffer with out_ready=1 -> out_valid=1 and out_data=0x7 in the same cycle, count stays 0.
  - Without the macro, out_valid rises one cycle later.
